// File: rtl/lsu.sv
// lsu: load/store unit bridging the execute stage to a request/grant data bus
`ifndef EXE_INFO_BUS_WIDTH
`define EXE_INFO_BUS_WIDTH 10
`define EXE_INST_L 2'b01
`define EXE_INST_S 2'b10
`define EXE_LB 2
`define EXE_LH 3
`define EXE_LW 4
`define EXE_LBU 5
`define EXE_LHU 6
`define EXE_SB 7
`define EXE_SH 8
`define EXE_SW 9
`endif
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_we_i,
  input  logic [4:0]                     rd_addr_i,
  input  logic [31:0]                    rd_mem_data_i,
  input  logic [31:0]                    mem_addr_i,
  input  logic [`EXE_INFO_BUS_WIDTH-1:0] exe_info_bus_i,
  output logic                           rd_we_o,
  output logic [4:0]                     rd_addr_o,
  output logic [31:0]                    rd_data_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [31:0]                    mem_addr_o,
  output logic [31:0]                    mem_wdata_o,
  output logic [3:0]                     mem_be_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [31:0]                    mem_rdata_i,
  output logic                           stallreq_o,
  output logic                           misalign_o,
  output logic                           bus_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  sz_q, sz_d, lo_q, lo_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d, sgn_q, sgn_d, err_q, err_d;
  logic [1:0]  op;
  logic        is_ld, is_st, is_mem, is_b, is_h, is_w, mis, idle, go, tmo;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  // decode the op field and detect misalignment against the access size
  always_comb begin
    op     = exe_info_bus_i[1:0];
    is_ld  = op == `EXE_INST_L && |{exe_info_bus_i[`EXE_LB], exe_info_bus_i[`EXE_LH], exe_info_bus_i[`EXE_LW],
                                    exe_info_bus_i[`EXE_LBU], exe_info_bus_i[`EXE_LHU]};
    is_st  = op == `EXE_INST_S && |{exe_info_bus_i[`EXE_SB], exe_info_bus_i[`EXE_SH], exe_info_bus_i[`EXE_SW]};
    is_mem = is_ld | is_st;
    is_b   = exe_info_bus_i[`EXE_LB] | exe_info_bus_i[`EXE_LBU] | exe_info_bus_i[`EXE_SB];
    is_h   = exe_info_bus_i[`EXE_LH] | exe_info_bus_i[`EXE_LHU] | exe_info_bus_i[`EXE_SH];
    is_w   = exe_info_bus_i[`EXE_LW] | exe_info_bus_i[`EXE_SW];
    mis    = (is_h & mem_addr_i[0]) | (is_w & |mem_addr_i[1:0]);
    idle   = state_q == IDLE;
    go     = idle & is_mem & ~mis;
    tmo    = cnt_q == TMO_LAST;
  end
  // next-state and capture logic; err_d is a one-cycle flag that lands in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    be_d    = be_q;
    sz_d    = sz_q;
    lo_d    = lo_q;
    rd_d    = rd_q;
    we_d    = we_q;
    sgn_d   = sgn_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        state_d = REQ;
        cnt_d   = '0;
        addr_d  = {mem_addr_i[31:2], 2'b00};
        lo_d    = mem_addr_i[1:0];
        we_d    = is_st;
        rd_d    = rd_addr_i;
        sz_d    = is_b ? 2'd0 : is_h ? 2'd1 : 2'd2;
        sgn_d   = exe_info_bus_i[`EXE_LB] | exe_info_bus_i[`EXE_LH];
        wdata_d = is_b ? {4{rd_mem_data_i[7:0]}} : is_h ? {2{rd_mem_data_i[15:0]}} : rd_mem_data_i;
        be_d    = is_b ? 4'b0001 << mem_addr_i[1:0] : is_h ? 4'b0011 << {mem_addr_i[1], 1'b0} : 4'hF;
      end
      REQ: begin
        cnt_d = mem_gnt_i ? 8'd0 : cnt_q + 8'd1;
        state_d = mem_gnt_i ? (we_q ? DONE : WAIT) : tmo ? DONE : REQ;
        err_d = ~mem_gnt_i & tmo;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        data_d = mem_rvalid_i ? mem_rdata_i : data_q;
        state_d = mem_rvalid_i | tmo ? DONE : WAIT;
        err_d = ~mem_rvalid_i & tmo;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // state and captured transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      be_q    <= '0;
      sz_q    <= '0;
      lo_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      be_q    <= be_d;
      sz_q    <= sz_d;
      lo_q    <= lo_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
    end
  end
  // load data extraction and output muxing
  always_comb begin
    ld_b        = data_q[{lo_q, 3'b000} +: 8];
    ld_h        = lo_q[1] ? data_q[31:16] : data_q[15:0];
    ld_ext      = sz_q == 2'd0 ? {{24{sgn_q & ld_b[7]}}, ld_b} :
                  sz_q == 2'd1 ? {{16{sgn_q & ld_h[15]}}, ld_h} : data_q;
    rd_we_o     = idle ? rd_we_i & ~is_mem : state_q == DONE & ~we_q & ~err_q;
    rd_addr_o   = state_q == DONE ? rd_q : rd_addr_i;
    rd_data_o   = state_q == DONE ? ld_ext : rd_mem_data_i;
    mem_req_o   = state_q == REQ;
    mem_we_o    = we_q;
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    mem_be_o    = be_q;
    stallreq_o  = go | state_q == REQ | state_q == WAIT;
    misalign_o  = ~rst & idle & is_mem & mis;
    bus_err_o   = err_q;
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against a behavioural bus model
`ifndef EXE_INFO_BUS_WIDTH
`define EXE_INFO_BUS_WIDTH 10
`define EXE_INST_L 2'b01
`define EXE_INST_S 2'b10
`define EXE_LB 2
`define EXE_LH 3
`define EXE_LW 4
`define EXE_LBU 5
`define EXE_LHU 6
`define EXE_SB 7
`define EXE_SH 8
`define EXE_SW 9
`endif
module tb_lsu;
  localparam int TMO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic rd_we_i = 1'b0, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [4:0] rd_addr_i = '0;
  logic [31:0] rd_mem_data_i = '0, mem_addr_i = '0, mem_rdata_i = '0;
  logic [`EXE_INFO_BUS_WIDTH-1:0] exe_info_bus_i = '0;
  logic rd_we_o, mem_req_o, mem_we_o, stallreq_o, misalign_o, bus_err_o;
  logic [4:0] rd_addr_o;
  logic [31:0] rd_data_o, mem_addr_o, mem_wdata_o;
  logic [3:0] mem_be_o;
  int n_run = 0, n_fail = 0;

  lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_mem_data_i(rd_mem_data_i),
    .mem_addr_i(mem_addr_i), .exe_info_bus_i(exe_info_bus_i), .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .stallreq_o(stallreq_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // k: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
  function automatic int size_of(input int k);
    return (k == 0 || k == 3 || k == 5) ? 1 : (k == 1 || k == 4 || k == 6) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_val(input int k, input logic [31:0] a, input logic [31:0] w);
    int sz = size_of(k);
    longint v = longint'(w) / (longint'(1) << (8 * (a % sz == 0 ? a % 4 : 0)));
    longint m = longint'(1) << (8 * sz);
    v = v % m;
    if ((k == 0 || k == 1) && v >= m / 2) v = v - m;
    return 32'(v);
  endfunction

  task automatic set_op(input int k);
    logic [7:0] oh;
    oh = 8'd1 << k;
    exe_info_bus_i = {oh, k < 5 ? `EXE_INST_L : `EXE_INST_S};
  endtask

  task automatic nop_op(input logic we, input logic [4:0] rd, input logic [31:0] d);
    exe_info_bus_i = '0;
    rd_we_i = we;
    rd_addr_i = rd;
    rd_mem_data_i = d;
    #1;
    chk("nop_we", 32'(rd_we_o), 32'(we));
    chk("nop_rd", 32'(rd_addr_o), 32'(rd));
    chk("nop_data", rd_data_o, d);
    chk("nop_stall", 32'(stallreq_o), 0);
  endtask

  // runs one memory op from IDLE; gd = REQ cycles before grant, rl = WAIT cycles before rvalid
  task automatic mem_op(input int k, input logic [31:0] a, input logic [31:0] d, input int gd, input int rl,
                        input logic [31:0] rdat, input logic [4:0] rd);
    int sz = size_of(k);
    bit ld = k < 5;
    bit to;
    int stalls = 0, exp_stalls;
    logic [31:0] exp_wd;
    logic [3:0] exp_be;
    set_op(k);
    mem_addr_i = a;
    rd_mem_data_i = d;
    rd_addr_i = rd;
    rd_we_i = ld;
    #1;
    if (a % sz != 0) begin
      chk("mis_pulse", 32'(misalign_o), 1);
      chk("mis_stall", 32'(stallreq_o), 0);
      chk("mis_we", 32'(rd_we_o), 0);
      chk("mis_req", 32'(mem_req_o), 0);
      tick();
      chk("mis_req_next", 32'(mem_req_o), 0);
      exe_info_bus_i = '0;
      #1;
      chk("mis_clear", 32'(misalign_o), 0);
      return;
    end
    chk("idle_mis", 32'(misalign_o), 0);
    chk("idle_we", 32'(rd_we_o), 0);
    stalls += int'(stallreq_o);
    exp_wd = sz == 1 ? d[7:0] * 32'h0101_0101 : sz == 2 ? d[15:0] * 32'h0001_0001 : d;
    exp_be = 4'(((1 << sz) - 1) << (a % 4));
    tick();
    to = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      chk("req_req", 32'(mem_req_o), 1);
      chk("req_addr", mem_addr_o, a - a % 4);
      chk("req_we", 32'(mem_we_o), 32'(!ld));
      chk("req_rdwe", 32'(rd_we_o), 0);
      if (!ld) begin
        chk("req_be", 32'(mem_be_o), 32'(exp_be));
        chk("req_wdata", mem_wdata_o, exp_wd);
      end
      stalls += int'(stallreq_o);
      if (i == gd) begin
        mem_gnt_i = 1'b1;
        mem_rvalid_i = ld;
        mem_rdata_i = ~rdat;
      end
      tick();
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (i == gd) begin
        to = 1'b0;
        break;
      end
    end
    if (!to && ld) begin
      to = 1'b1;
      for (int j = 0; j < TMO; j++) begin
        chk("wait_req", 32'(mem_req_o), 0);
        chk("wait_rdwe", 32'(rd_we_o), 0);
        stalls += int'(stallreq_o);
        if (j == rl) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = rdat;
        end
        tick();
        mem_rvalid_i = 1'b0;
        if (j == rl) begin
          to = 1'b0;
          break;
        end
      end
    end
    exp_stalls = 1 + (gd < TMO ? gd + 1 : TMO) + ((ld && gd < TMO) ? (rl < TMO ? rl + 1 : TMO) : 0);
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("done_stall", 32'(stallreq_o), 0);
    chk("done_req", 32'(mem_req_o), 0);
    chk("done_buserr", 32'(bus_err_o), 32'(to));
    chk("done_we", 32'(rd_we_o), 32'(ld && !to));
    if (ld && !to) begin
      chk("done_rd", 32'(rd_addr_o), 32'(rd));
      chk("done_data", rd_data_o, load_val(k, a, rdat));
    end
    exe_info_bus_i = '0;
    rd_we_i = 1'b0;
    tick();
    chk("post_buserr", 32'(bus_err_o), 0);
    chk("post_stall", 32'(stallreq_o), 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req", 32'(mem_req_o), 0);
    chk("rst_we", 32'(mem_we_o), 0);
    chk("rst_be", 32'(mem_be_o), 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_mis", 32'(misalign_o), 0);
    chk("rst_buserr", 32'(bus_err_o), 0);
    chk("rst_stall", 32'(stallreq_o), 0);
    rst = 1'b0;
    nop_op(1'b1, 5'd5, 32'h1234);
    tick();
    mem_op(0, 32'h1003, 32'h0, 0, 0, 32'h80FF_FF00, 5'd7);
    mem_op(6, 32'h2002, 32'hABCD, 4, 0, 32'h0, 5'd0);
    mem_op(2, 32'h3001, 32'h0, 0, 0, 32'h0, 5'd3);
    mem_op(4, 32'h4002, 32'h0, 100, 0, 32'h0, 5'd9);
    mem_op(3, 32'h5002, 32'h0, 1, 100, 32'h1234_5678, 5'd10);
    mem_op(2, 32'h4000, 32'h0, 0, 0, 32'h0, 5'd2);
    // reset while waiting for read data; late rvalid must be ignored
    set_op(2);
    mem_addr_i = 32'h6000;
    rd_we_i = 1'b1;
    rd_addr_i = 5'd4;
    tick();
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    exe_info_bus_i = '0;
    rd_we_i = 1'b0;
    tick();
    rst = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    chk("rstw_req", 32'(mem_req_o), 0);
    chk("rstw_we", 32'(rd_we_o), 0);
    chk("rstw_stall", 32'(stallreq_o), 0);
    tick();
    mem_rvalid_i = 1'b0;
    chk("rstw_we2", 32'(rd_we_o), 0);
    chk("rstw_req2", 32'(mem_req_o), 0);
    for (int r = 0; r < 60; r++) begin
      int k = int'($urandom_range(0, 7));
      logic [31:0] a = $urandom;
      int gd = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
      int rl = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) a = a - a % size_of(k);
      mem_op(k, a, $urandom, gd, rl, $urandom, 5'($urandom));
      nop_op(1'($urandom), 5'($urandom), $urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
